// File: rtl/video_pkg.sv
// video_pkg: shared screen geometry and fetch FSM state encoding for the video path.
package video_pkg;
  localparam int SCREEN_WIDTH = 320;
  localparam int SCREEN_HEIGHT = 240;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_ACTIVE, FETCH_DONE} fetch_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: first-word-fall-through pixel FIFO; dout shows the head, or 0 when empty.
module pixel_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  // full is judged on the occupancy before any same-cycle pop
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? 8'h00 : mem[rd_ptr];
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/video_fetch_buffer.sv
// video_fetch_buffer: raster-order pixel prefetcher feeding a FWFT FIFO for display timing.
// Optional VIDEO_FETCH_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflowCount output.
module video_fetch_buffer
  import video_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frameStart,
  output logic [8:0] videoXCoord,
  output logic [7:0] videoYCoord,
  input  logic [7:0] videoData,
  input  logic       videoDataReady,
  input  logic       pixelRead,
  output logic [7:0] pixelData,
  output logic       pixelValid,
  output logic       frameDone,
  output logic       underflow
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
  , output logic [15:0] underflowCount
`endif
);
  fetch_state_t state, next_state;
  logic full, empty, accept, last_x, last_pixel, empty_pop;
  logic [$clog2(DEPTH):0] fill;
  assign last_x = videoXCoord == 9'(WIDTH - 1);
  assign last_pixel = last_x && videoYCoord == 8'(HEIGHT - 1);
  assign accept = state == FETCH_ACTIVE && videoDataReady && !frameStart && !full;
  assign empty_pop = pixelRead && empty && !frameStart;
  assign pixelValid = fill != '0;
  assign frameDone = state == FETCH_DONE;
  always_comb begin
    next_state = state;
    next_state = frameStart ? FETCH_ACTIVE : (accept && last_pixel) ? FETCH_DONE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= FETCH_IDLE;
    else state <= next_state;
  end
  // the final pixel's coordinates are held so DONE keeps presenting it
  always_ff @(posedge clock) begin
    if (reset || frameStart) begin
      videoXCoord <= '0;
      videoYCoord <= '0;
    end else if (accept && !last_pixel) begin
      videoXCoord <= last_x ? 9'd0 : videoXCoord + 9'd1;
      videoYCoord <= last_x ? videoYCoord + 8'd1 : videoYCoord;
    end
  end
  always_ff @(posedge clock) begin
    if (reset || frameStart) underflow <= 1'b0;
    else if (empty_pop) underflow <= 1'b1;
  end
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) underflowCount <= '0;
    else if (empty_pop && underflowCount != 16'hFFFF) underflowCount <= underflowCount + 16'd1;
  end
`endif
  pixel_fifo #(.DEPTH(DEPTH)) fifo (
    .clock(clock),
    .reset(reset),
    .push(accept),
    .pop(pixelRead && !frameStart),
    .flush(frameStart),
    .din(videoData),
    .dout(pixelData),
    .full(full),
    .empty(empty),
    .count(fill)
  );
endmodule

// File: tb/tb_video_fetch_buffer.sv
// tb_video_fetch_buffer: directed self-checking bench; a second instance gets a private
// frameStart so a mid-frame restart at (100,50) rides on the main full-frame stream.
module tb_video_fetch_buffer;
  logic clock = 0, reset = 1, frameStart = 0, videoDataReady = 0, pixelRead = 0, fs2 = 0;
  logic [7:0] videoData = 0;
  logic [8:0] x, x2;
  logic [7:0] y, y2, pd, pd2;
  logic pv, pv2, done, done2, uf, uf2;
  int vectors = 0, miscompares = 0;
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
  logic [15:0] ucnt, ucnt2;
`endif

  always #5 clock = ~clock;

  video_fetch_buffer dut (
    .clock(clock), .reset(reset), .frameStart(frameStart),
    .videoXCoord(x), .videoYCoord(y), .videoData(videoData), .videoDataReady(videoDataReady),
    .pixelRead(pixelRead), .pixelData(pd), .pixelValid(pv), .frameDone(done), .underflow(uf)
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
    , .underflowCount(ucnt)
`endif
  );

  video_fetch_buffer mid (
    .clock(clock), .reset(reset), .frameStart(frameStart || fs2),
    .videoXCoord(x2), .videoYCoord(y2), .videoData(videoData), .videoDataReady(videoDataReady),
    .pixelRead(pixelRead), .pixelData(pd2), .pixelValid(pv2), .frameDone(done2), .underflow(uf2)
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
    , .underflowCount(ucnt2)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_data", 32'(pd), 0);
    check("rst_valid", 32'(pv), 0);
    check("rst_done", 32'(done), 0);
    check("rst_uf", 32'(uf), 0);
    frameStart = 1;
    tick();
    frameStart = 0;
    check("start_x", 32'(x), 0);
    check("start_y", 32'(y), 0);
    videoData = 8'hA5;
    videoDataReady = 1;
    tick();
    videoDataReady = 0;
    check("a5_valid", 32'(pv), 1);
    check("a5_data", 32'(pd), 32'hA5);
    check("a5_x", 32'(x), 1);
    frameStart = 1;
    tick();
    frameStart = 0;
    check("flush_valid", 32'(pv), 0);
    check("flush_x", 32'(x), 0);
    for (int i = 0; i < 16; i++) begin
      videoData = 8'(8'h10 + i);
      videoDataReady = 1;
      tick();
    end
    check("fill16_x", 32'(x), 16);
    videoData = 8'hEE;
    tick();
    videoDataReady = 0;
    check("full_hold_x", 32'(x), 16);
    check("full_head", 32'(pd), 32'h10);
    pixelRead = 1;
    tick();
    pixelRead = 0;
    check("pop_next_head", 32'(pd), 32'h11);
    videoData = 8'h20;
    videoDataReady = 1;
    tick();
    videoDataReady = 0;
    check("refetch_x", 32'(x), 17);
    pixelRead = 1;
    for (int i = 0; i < 15; i++) tick();
    check("pixel16_data", 32'(pd), 32'h20);
    tick();
    check("drained_valid", 32'(pv), 0);
    tick();
    check("uf_set", 32'(uf), 1);
    check("uf_data", 32'(pd), 0);
    tick();
    tick();
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
    check("uf_count3", 32'(ucnt), 3);
`endif
    frameStart = 1;
    tick();
    frameStart = 0;
    pixelRead = 0;
    check("uf_cleared", 32'(uf), 0);
`ifdef VIDEO_FETCH_UNDERFLOW_COUNT_EN
    check("uf_count_kept", 32'(ucnt), 3);
`endif
    for (int k = 0; k < 76800; k++) begin
      videoData = (k == 16100) ? 8'h3C : 8'(k);
      videoDataReady = 1;
      pixelRead = k != 0;
      fs2 = k == 16100;
      if (k == 16100) begin
        check("mid_at_x", 32'(x2), 100);
        check("mid_at_y", 32'(y2), 50);
      end
      tick();
      if (k == 319) begin
        check("wrap_x", 32'(x), 0);
        check("wrap_y", 32'(y), 1);
        check("wrap_data", 32'(pd), 32'h3F);
      end
      if (k == 16100) begin
        check("mid_valid", 32'(pv2), 0);
        check("mid_x", 32'(x2), 0);
        check("mid_y", 32'(y2), 0);
        check("main_3c", 32'(pd), 32'h3C);
      end
      if (k == 76798) check("not_done_yet", 32'(done), 0);
    end
    fs2 = 0;
    pixelRead = 0;
    check("done", 32'(done), 1);
    check("done_x", 32'(x), 319);
    check("done_y", 32'(y), 239);
    check("done_data", 32'(pd), 32'hFF);
    check("done_uf", 32'(uf), 0);
    videoData = 8'h55;
    for (int i = 0; i < 3; i++) tick();
    videoDataReady = 0;
    check("ignored_x", 32'(x), 319);
    check("ignored_data", 32'(pd), 32'hFF);
    frameStart = 1;
    tick();
    frameStart = 0;
    check("restart_done", 32'(done), 0);
    check("restart_x", 32'(x), 0);
    check("restart_y", 32'(y), 0);
    check("restart_valid", 32'(pv), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
